sample_rom_fetch: RTL and testbench
===================================

SAMPLE_ROM_FETCH -- requirements
Module: sample_rom_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, ROM byte-address width (bank bits + 16-bit counter).
REQ-002 SHALL have parameter BANK_W, default 2, equal to ADDR_W-16.
REQ-003 CLK_32M  input  1  sole clock; all state on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sample_addr_wr  input  2  byte-lane load strobes: bit0 = addr[7:0], bit1 = addr[15:8]; one-cycle pulses.
REQ-006 sample_addr  input  16  address value from the MCU; sampled only in lanes flagged by sample_addr_wr.
REQ-007 sample_inc  input  1  one-cycle pulse; MCU has consumed the current byte.
REQ-008 sample_bank  input  BANK_W  upper address bits; sampled whenever a fetch is issued.
REQ-009 sample_rom_data  output  8  byte at the current address.
REQ-010 sample_valid  output  1  high when sample_rom_data matches the current address.
REQ-011 rom_addr  output  ADDR_W-1  16-bit-word address to the SDRAM port.
REQ-012 rom_req  output  1  toggle handshake: each toggle requests one word.
REQ-013 rom_ack  input  1  toggle handshake: completion when it equals rom_req.
REQ-014 rom_data  input  16  word data, valid in the cycle rom_ack matches; low byte = even address.

Function
REQ-015 SHALL hold a 16-bit counter cur_addr; on sample_addr_wr, the flagged lanes load from sample_addr; 2'b11 loads both.
REQ-016 On sample_inc, cur_addr SHALL increment by 1 and wrap 16'hFFFF -> 16'h0000; sample_bank SHALL be unaffected.
REQ-017 A simultaneous sample_addr_wr and sample_inc SHALL apply the write; the increment SHALL be discarded.
REQ-018 SHALL keep a one-word cache: cached word address, cached word and a cache_ok flag.
REQ-019 When {sample_bank, cur_addr[15:1]} equals the cached word address and cache_ok is set, sample_rom_data SHALL be the cache byte selected by cur_addr[0].
REQ-020 In that case, sample_valid SHALL be high in the cycle after the address update (registered output).
REQ-021 On a cache miss, sample_valid SHALL drop in the cycle after the address update and remain low until the fill completes.
REQ-022 SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-023 IDLE -> ISSUE on a cache miss.
REQ-024 ISSUE: drive rom_addr = {sample_bank, cur_addr[15:1]}, toggle rom_req and latch the requested word address; go to WAIT.
REQ-025 WAIT: when rom_ack == rom_req, capture rom_data into the cache and return to IDLE.
REQ-026 If the requested word address no longer matches the current word when the ack arrives, the captured word SHALL be cached as-is and the FSM SHALL go to ISSUE, not IDLE.
REQ-027 At most one request SHALL be outstanding; address changes while in WAIT SHALL NOT toggle rom_req.
REQ-028 Miss-to-valid latency SHALL be 2 cycles + SDRAM latency (1 cycle ISSUE, 1 cycle data register).
REQ-029 A sample_inc while sample_valid is low SHALL still advance cur_addr; the MCU sees the byte present at its read.

Reset
REQ-030 reset_n low SHALL asynchronously force the following.
  - cur_addr = 0, cache_ok = 0, FSM = IDLE.
  - rom_req = rom_ack-equivalent 0, rom_addr = 0.
  - sample_rom_data = 8'h80 (DAC midpoint), sample_valid = 0.
REQ-031 Reset while in WAIT SHALL abandon the request; the first post-reset request SHALL start only after rom_ack == rom_req has been observed.
REQ-032 After reset release, with cache_ok = 0, the FSM SHALL issue a fetch of word 0 on the first cycle.

Configuration
REQ-033 Macro SAMPLE_PREFETCH_EN.
  - Defined: on entering IDLE with cur_addr[0]==1, the next word ({bank, cur_addr[15:1]+1}, wrapping within the bank) SHALL be fetched into a second cache entry.
  - Defined: a sample_inc crossing to the next word SHALL promote that entry, with sample_valid staying high.
  - Defined: a prefetch in flight SHALL complete before any demand miss is issued.
REQ-034 Undefined: single-entry cache only; a word crossing always misses (REQ-028 latency).

Structure
REQ-035 The shared package SHALL hold the FSM state enum (IDLE, ISSUE, WAIT), the reset byte constant 8'h80 and the ADDR_W default.
REQ-036 The word cache entry (tag, word, valid, byte select) SHALL be one sub-module, sample_word_cache, instantiated once (twice with SAMPLE_PREFETCH_EN).

Verification
REQ-037 Reset, SDRAM ack after 4 cycles with word 16'hA155 -> rom_addr=0, one rom_req toggle, then sample_rom_data=8'h55 and sample_valid=1.
REQ-038 Load 16'h1234 via wr 2'b01 then 2'b10, then inc -> fetches word 0x091A and sample_rom_data = byte at 0x1234, then a 0x1235 hit without a new rom_req.
REQ-039 cur_addr=16'hFFFF, bank=1, inc -> cur_addr=0, rom_addr={1,15'h0}, bank unchanged.
REQ-040 wr 2'b01 with value 8'h10 in the same cycle as inc at address 0x00FF -> cur_addr=0x0010, no increment.
REQ-041 Address rewritten to 0x4000 during WAIT for 0x2000 -> exactly one extra request, for word 0x2000, after the first ack; final data from 0x4000.
REQ-042 SAMPLE_PREFETCH_EN, inc from 0x0011 to 0x0012 after the prefetch completes -> sample_valid never drops; no demand request.

Source files
------------

// File: rtl/sample_rom_fetch_pkg.sv
// -----------------------------------------------------------------------------
// sample_rom_fetch_pkg
// Shared definitions for the sample ROM fetch block:
//   - fetch_state_e : request FSM states (IDLE, ISSUE, WAIT)
//   - RESET_BYTE    : byte presented to the DAC path while nothing is valid
//   - ADDR_W_DEF    : default ROM byte-address width (bank bits + 16)
//   - word_byte()   : picks the byte of a 16-bit word for an even/odd address
// -----------------------------------------------------------------------------
package sample_rom_fetch_pkg;

  localparam int         ADDR_W_DEF = 18;
  localparam logic [7:0] RESET_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  // Low byte of the word holds the even address.
  function automatic logic [7:0] word_byte(input logic [15:0] word, input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sample_rom_fetch_if.sv
// -----------------------------------------------------------------------------
// sample_rom_fetch_if
// Word-fetch port between the sample fetcher and the SDRAM arbiter.
//   rom_addr : 16-bit-word address (ADDR_W-1 bits)
//   rom_req  : toggles once per requested word
//   rom_ack  : toggles back to equal rom_req when the word is delivered
//   rom_data : word data, valid in the cycle rom_ack matches rom_req
// Modports: master = fetcher side, slave = SDRAM side.
// -----------------------------------------------------------------------------
interface sample_rom_fetch_if
  import sample_rom_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-2:0] rom_addr;
  logic              rom_req;
  logic              rom_ack;
  logic [15:0]       rom_data;

  modport master (output rom_addr, output rom_req, input rom_ack, input rom_data);
  modport slave  (input rom_addr, input rom_req, output rom_ack, output rom_data);

endinterface

// File: rtl/sample_word_cache.sv
// -----------------------------------------------------------------------------
// sample_word_cache
// One cached ROM word: tag (word address), data word, valid flag and the
// even/odd byte select for the current byte address.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears valid only)
//   load_i         : write load_tag_i/load_word_i into the entry, set valid
//   byte_sel_i     : current byte address bit 0
//   valid_o, tag_o : entry state, compared against lookups by the parent
//   byte_o         : selected byte of the cached word
// -----------------------------------------------------------------------------
module sample_word_cache
  import sample_rom_fetch_pkg::*;
#(
  parameter int TAG_W = ADDR_W_DEF - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TAG_W-1:0] load_tag_i,
  input  logic [15:0]      load_word_i,
  input  logic             byte_sel_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [7:0]       byte_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Tag and word are only meaningful while valid_q is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      tag_q  <= load_tag_i;
      word_q <= load_word_i;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign byte_o  = word_byte(word_q, byte_sel_i);

endmodule

// File: rtl/sample_rom_fetch.sv
// -----------------------------------------------------------------------------
// sample_rom_fetch
// Streams sample bytes from a 16-bit-wide SDRAM ROM to an 8-bit MCU.
// The MCU loads a 16-bit byte address lane by lane and pulses sample_inc
// after consuming each byte; the block keeps the addressed word cached and
// refetches over a toggle handshake on a miss.
// Ports:
//   CLK_32M         : clock
//   reset_n         : asynchronous active-low reset
//   sample_addr_wr  : lane load strobes (bit0 -> addr[7:0], bit1 -> addr[15:8])
//   sample_addr     : address value for the flagged lanes
//   sample_inc      : advance the byte address by one (wraps at 16 bits)
//   sample_bank     : upper ROM address bits
//   sample_rom_data : byte at the current address (registered)
//   sample_valid    : sample_rom_data belongs to the current address
//   rom             : word-fetch port (sample_rom_fetch_if.master)
// Build option: define SAMPLE_PREFETCH_EN to add a second cache entry that
// prefetches the following word while the MCU reads the odd byte.
// -----------------------------------------------------------------------------
module sample_rom_fetch
  import sample_rom_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = ADDR_W - 16
) (
  input  logic                  CLK_32M,
  input  logic                  reset_n,
  input  logic [1:0]            sample_addr_wr,
  input  logic [15:0]           sample_addr,
  input  logic                  sample_inc,
  input  logic [BANK_W-1:0]     sample_bank,
  output logic [7:0]            sample_rom_data,
  output logic                  sample_valid,
  sample_rom_fetch_if.master    rom
);

  localparam int TAG_W = ADDR_W - 1;

  fetch_state_e     state_q, state_d;
  logic [15:0]      cur_addr_q, cur_addr_d;
  logic             rom_req_q, rom_req_d;
  logic [TAG_W-1:0] rom_addr_q, rom_addr_d;
  logic             pf_q, pf_d;
  logic             valid_q;
  logic [7:0]       data_q;

  logic [TAG_W-1:0] cur_tag, issue_tag;
  logic             ack_match, fill, miss, pf_want, bypass, hit_any;
  logic [7:0]       byte_any, byte_rom;

  logic             e0_valid, e0_load, hit0;
  logic [TAG_W-1:0] e0_tag;
  logic [7:0]       e0_byte;
  logic             hit1;
  logic [7:0]       e1_byte;

  // Address register: a lane write wins over a same-cycle increment.
  always_comb begin
    cur_addr_d = cur_addr_q;
    if (sample_addr_wr != 2'b00) begin
      if (sample_addr_wr[0]) cur_addr_d[7:0]  = sample_addr[7:0];
      if (sample_addr_wr[1]) cur_addr_d[15:8] = sample_addr[15:8];
    end else if (sample_inc) begin
      cur_addr_d = cur_addr_q + 16'd1;
    end
  end

  assign cur_tag   = {sample_bank, cur_addr_q[15:1]};
  assign ack_match = (rom.rom_ack == rom_req_q);
  assign fill      = (state_q == WAIT) && ack_match;
  assign hit0      = e0_valid && (e0_tag == cur_tag);
  assign miss      = !(hit0 || hit1);

  // Forward the arriving word straight to the output register so the fill
  // costs only one data-register cycle after the ack.
  assign byte_rom = word_byte(rom.rom_data, cur_addr_q[0]);
  assign bypass   = fill && (rom_addr_q == cur_tag);
  assign hit_any  = bypass || hit0 || hit1;
  assign byte_any = bypass ? byte_rom : (hit0 ? e0_byte : e1_byte);

  sample_word_cache #(.TAG_W(TAG_W)) u_entry0 (
    .clk_i       (CLK_32M),
    .rst_ni      (reset_n),
    .load_i      (e0_load),
    .load_tag_i  (rom_addr_q),
    .load_word_i (rom.rom_data),
    .byte_sel_i  (cur_addr_q[0]),
    .valid_o     (e0_valid),
    .tag_o       (e0_tag),
    .byte_o      (e0_byte)
  );

`ifdef SAMPLE_PREFETCH_EN
  // Whichever entry holds the current word is the primary; the other one
  // receives the prefetch. A crossing into the prefetched word therefore
  // promotes it simply by hitting, with no copy and no valid gap.
  logic             fill_slot_q, fill_slot_d;
  logic [TAG_W-1:0] next_tag;
  logic             e1_valid, e1_load;
  logic [TAG_W-1:0] e1_tag;

  assign next_tag  = {sample_bank, cur_addr_q[15:1] + 15'd1};
  assign hit1      = e1_valid && (e1_tag == cur_tag);
  assign pf_want   = cur_addr_q[0]
                     && !(e0_valid && (e0_tag == next_tag))
                     && !(e1_valid && (e1_tag == next_tag));
  assign issue_tag = (pf_q && !miss) ? next_tag : cur_tag;
  assign e0_load   = fill && !fill_slot_q;
  assign e1_load   = fill && fill_slot_q;

  always_comb begin
    fill_slot_d = fill_slot_q;
    if (state_q == ISSUE) begin
      fill_slot_d = (pf_q && !miss) ? hit0 : 1'b0;
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      fill_slot_q <= 1'b0;
    end else begin
      fill_slot_q <= fill_slot_d;
    end
  end

  sample_word_cache #(.TAG_W(TAG_W)) u_entry1 (
    .clk_i       (CLK_32M),
    .rst_ni      (reset_n),
    .load_i      (e1_load),
    .load_tag_i  (rom_addr_q),
    .load_word_i (rom.rom_data),
    .byte_sel_i  (cur_addr_q[0]),
    .valid_o     (e1_valid),
    .tag_o       (e1_tag),
    .byte_o      (e1_byte)
  );
`else
  assign hit1      = 1'b0;
  assign e1_byte   = 8'h00;
  assign pf_want   = 1'b0;
  assign issue_tag = cur_tag;
  assign e0_load   = fill;
`endif

  // Request FSM. A new request only leaves IDLE once rom_ack matches rom_req,
  // which also absorbs an ack still owed from a request abandoned by reset.
  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    pf_d       = pf_q;
    case (state_q)
      IDLE: begin
        if (ack_match) begin
          if (miss) begin
            state_d = ISSUE;
            pf_d    = 1'b0;
          end else if (pf_want) begin
            state_d = ISSUE;
            pf_d    = 1'b1;
          end
        end
      end
      ISSUE: begin
        // A demand miss that appeared since IDLE overrides a planned prefetch.
        rom_addr_d = issue_tag;
        rom_req_d  = ~rom_req_q;
        pf_d       = pf_q && !miss;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ack_match) begin
          // A demand word that went stale while in flight is kept in the
          // cache but refetched for the address the MCU has moved to.
          state_d = (!pf_q && (rom_addr_q != cur_tag)) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_addr_q <= 16'h0000;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      pf_q       <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= RESET_BYTE;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      pf_q       <= pf_d;
      valid_q    <= hit_any;
      // Hold the last good byte while invalid; the MCU reads what is present.
      if (hit_any) begin
        data_q <= byte_any;
      end
    end
  end

  assign rom.rom_addr    = rom_addr_q;
  assign rom.rom_req     = rom_req_q;
  assign sample_rom_data = data_q;
  assign sample_valid    = valid_q;

endmodule

// File: tb/tb_sample_rom_fetch.sv
module tb_sample_rom_fetch;

  localparam int ADDR_W = 18;
  localparam int BANK_W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr = 2'b00;
  logic [15:0] saddr = 16'h0000;
  logic        inc = 1'b0;
  logic [1:0]  bank = 2'd0;
  logic [7:0]  sdata;
  logic        svalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sample_rom_fetch_if #(.ADDR_W(ADDR_W)) rom_if ();

  sample_rom_fetch #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .CLK_32M         (clk),
    .reset_n         (rst_n),
    .sample_addr_wr  (wr),
    .sample_addr     (saddr),
    .sample_inc      (inc),
    .sample_bank     (bank),
    .sample_rom_data (sdata),
    .sample_valid    (svalid),
    .rom             (rom_if)
  );

  // ROM contents: word w = {A1 ^ w[7:0], 55 ^ w[7:0] ^ bank}; word 0 = A155.
  function automatic logic [15:0] mem_word(input logic [16:0] w);
    return {8'hA1 ^ w[7:0], 8'h55 ^ w[7:0] ^ {6'b0, w[16:15]}};
  endfunction

  // SDRAM model: answers each req toggle after a fixed delay, not reset.
  logic        ack_q = 1'b0;
  logic [15:0] rdata_q = 16'h0000;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [16:0] lat_addr = '0;
  assign rom_if.rom_ack  = ack_q;
  assign rom_if.rom_data = rdata_q;

  always @(posedge clk) begin
    if (!busy) begin
      if (rom_if.rom_req != ack_q) begin
        busy     <= 1'b1;
        cnt      <= 3;
        lat_addr <= rom_if.rom_addr;
      end
    end else if (cnt == 0) begin
      rdata_q <= mem_word(lat_addr);
      ack_q   <= ~ack_q;
      busy    <= 1'b0;
    end else begin
      cnt <= cnt - 1;
    end
  end

  // Request toggle counter.
  int   req_cnt = 0;
  logic req_prev = 1'b0;
  always @(posedge clk) begin
    req_prev <= rom_if.rom_req;
    if (rom_if.rom_req != req_prev) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] w, input logic [15:0] a, input logic i, input logic [1:0] b);
    @(posedge clk); #1;
    wr = w; saddr = a; inc = i; bank = b;
    @(posedge clk); #1;
    wr = 2'b00; inc = 1'b0;
  endtask

  // Wait until the output is valid with no request outstanding for 6 cycles.
  task automatic settle(input string name);
    int stable = 0;
    logic ok = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (svalid && (rom_if.rom_req == rom_if.rom_ack)) stable++;
      else stable = 0;
      if (stable >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_settle"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  wr;
    logic [15:0] addr;
    logic        inc;
    logic [1:0]  bank;
    logic [7:0]  exp_data;
    int          exp_reqs;
    logic [16:0] exp_rom_addr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic ok;
    logic early;
    logic dropped;

    vecs[0]  = '{2'b00, 16'h0000, 1'b1, 2'd0, 8'hA1, 0, 17'h00000};
    vecs[1]  = '{2'b00, 16'h0000, 1'b1, 2'd0, 8'h54, 1, 17'h00001};
    vecs[2]  = '{2'b01, 16'h0034, 1'b0, 2'd0, 8'h4F, 1, 17'h0001A};
    vecs[3]  = '{2'b10, 16'h1299, 1'b0, 2'd0, 8'h4F, 1, 17'h0091A};
    vecs[4]  = '{2'b00, 16'h0000, 1'b1, 2'd0, 8'hBB, 0, 17'h0091A};
    vecs[5]  = '{2'b11, 16'h00FF, 1'b0, 2'd0, 8'hDE, 1, 17'h0007F};
    vecs[6]  = '{2'b01, 16'h0010, 1'b1, 2'd0, 8'h5D, 1, 17'h00008};
    vecs[7]  = '{2'b11, 16'hFFFF, 1'b0, 2'd1, 8'h5E, 1, 17'h0FFFF};
    vecs[8]  = '{2'b00, 16'h0000, 1'b1, 2'd1, 8'h54, 1, 17'h08000};
    vecs[9]  = '{2'b00, 16'h0000, 1'b1, 2'd1, 8'hA1, 0, 17'h08000};
    vecs[10] = '{2'b00, 16'h0000, 1'b1, 2'd0, 8'h54, 1, 17'h00001};
    vecs[11] = '{2'b11, 16'h0003, 1'b0, 2'd0, 8'hA0, 0, 17'h00001};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data",    32'(sdata), 32'h80);
    check("rst_valid",   32'(svalid), 32'd0);
    check("rst_req",     32'(rom_if.rom_req), 32'd0);
    check("rst_rom_addr", 32'(rom_if.rom_addr), 32'd0);

    // First fetch after release: word 0, one toggle
    base = req_cnt;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("first_issue_req", 32'(rom_if.rom_req), 32'd1);
    settle("boot");
    check("boot_rom_addr", 32'(rom_if.rom_addr), 32'd0);
    check("boot_reqs",     32'(req_cnt - base), 32'd1);
    check("boot_data",     32'(sdata), 32'h55);
    check("boot_valid",    32'(svalid), 32'd1);

    // Table of single-step address operations
    for (int v = 0; v < 12; v++) begin
      base = req_cnt;
      apply(vecs[v].wr, vecs[v].addr, vecs[v].inc, vecs[v].bank);
      settle($sformatf("vec%0d", v));
      check($sformatf("vec%0d_valid", v), 32'(svalid), 32'd1);
      check($sformatf("vec%0d_data", v),  32'(sdata), 32'(vecs[v].exp_data));
`ifndef SAMPLE_PREFETCH_EN
      check($sformatf("vec%0d_reqs", v),  32'(req_cnt - base), 32'(vecs[v].exp_reqs));
      check($sformatf("vec%0d_rom_addr", v), 32'(rom_if.rom_addr), 32'(vecs[v].exp_rom_addr));
`endif
    end

    // Increment while invalid still advances the address
    base = req_cnt;
    apply(2'b11, 16'h0040, 1'b0, 2'd0);
    apply(2'b00, 16'h0000, 1'b1, 2'd0);
    check("inc_invalid_low", 32'(svalid), 32'd0);
    settle("inc_invalid");
    check("inc_invalid_data", 32'(sdata), 32'h81);
`ifndef SAMPLE_PREFETCH_EN
    check("inc_invalid_reqs", 32'(req_cnt - base), 32'd1);
`endif

    // Address rewritten while a fetch is in flight
    base = req_cnt;
    apply(2'b11, 16'h2000, 1'b0, 2'd0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rom_if.rom_req != rom_if.rom_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("rewrite_wait_req", 32'(ok), 32'd1);
    apply(2'b11, 16'h4000, 1'b0, 2'd0);
    settle("rewrite");
    check("rewrite_reqs",     32'(req_cnt - base), 32'd2);
    check("rewrite_rom_addr", 32'(rom_if.rom_addr), 32'h02000);
    check("rewrite_data",     32'(sdata), 32'h55);

    // Reset while a request is outstanding (req 1->0 pending, ack still 1)
    if (rom_if.rom_req == 1'b0) begin
      apply(2'b11, 16'h0100, 1'b0, 2'd0);
      settle("pre_rst");
    end
    apply(2'b11, 16'h0200, 1'b0, 2'd0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rom_if.rom_req != rom_if.rom_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_rst_pending", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("wait_rst_req",   32'(rom_if.rom_req), 32'd0);
    check("wait_rst_valid", 32'(svalid), 32'd0);
    check("wait_rst_data",  32'(sdata), 32'h80);
    check("wait_rst_addr",  32'(rom_if.rom_addr), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rom_if.rom_ack == 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (rom_if.rom_req != 1'b0) early = 1'b1;
    end
    check("wait_rst_ack_seen", 32'(ok), 32'd1);
    check("wait_rst_no_early", 32'(early), 32'd0);
    settle("wait_rst");
    check("wait_rst_final_data", 32'(sdata), 32'h55);

`ifdef SAMPLE_PREFETCH_EN
    // Crossing into a prefetched word keeps valid high
    apply(2'b11, 16'h0011, 1'b0, 2'd0);
    settle("pf_load");
    base = req_cnt;
    apply(2'b00, 16'h0000, 1'b1, 2'd0);
    dropped = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!svalid) dropped = 1'b1;
    end
    check("pf_valid_kept", 32'(dropped), 32'd0);
    check("pf_data",       32'(sdata), 32'h5C);
    check("pf_reqs",       32'(req_cnt - base), 32'd0);
`else
    dropped = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
